// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART blocks:
//   - DATA_W       : serial payload width (8 bits)
//   - state_e      : receiver FSM state encoding
//   - clks_per_bit : rounded clock-to-baud ratio
//   - half_bit     : half of a bit period, used to reach mid-bit sampling
// Configuration macro: UART_RX_PARITY_EN adds the ST_PARITY state.
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3,
        ST_BREAK  = 3'd4
`ifdef UART_RX_PARITY_EN
        ,
        ST_PARITY = 3'd5
`endif
    } state_e;

    // Round to the nearest integer ratio rather than truncating.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

    function automatic int half_bit(input int cpb);
        return cpb / 2;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchronizer for an asynchronous serial line plus a falling-edge
// detector on the synchronized value. All flops reset to 1 (line idle level)
// so that reset release never produces a spurious falling edge.
// Ports:
//   clk     in   system clock
//   rst     in   asynchronous active-high reset
//   rx_i    in   raw asynchronous serial line
//   rx_s_o  out  synchronized line
//   fall_o  out  one-cycle high when rx_s_o has just gone high-to-low
// -----------------------------------------------------------------------------
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx_i,
    output logic rx_s_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= rx_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rx_s_o = sync_q;
    assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver (8E1 when UART_RX_PARITY_EN is defined).
// Parameters:
//   CLK_FREQ  system clock frequency in Hz
//   BAUD      serial bit rate in bit/s
// Ports:
//   clk            in   system clock, rising edge
//   rst            in   asynchronous active-high reset
//   rx             in   asynchronous serial line, idle high
//   rx_data        out  last correctly received byte
//   rx_valid       out  one-cycle pulse when rx_data is updated
//   rx_frame_err   out  one-cycle pulse on a bad (low) stop bit
//   rx_parity_err  out  (UART_RX_PARITY_EN only) one-cycle pulse on even-parity
//                       mismatch with a good stop bit; rx_valid is suppressed
//   rx_busy        out  high whenever the FSM is outside IDLE
// Configuration macro: UART_RX_PARITY_EN.
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 12000000,
    parameter int BAUD     = 115200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_frame_err,
`ifdef UART_RX_PARITY_EN
    output logic              rx_parity_err,
`endif
    output logic              rx_busy
);

    localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD);
    localparam int HALF  = half_bit(CPB);
    localparam int CNT_W = $clog2(CPB);

    // The detection cycle itself counts as the first clock of the half bit,
    // so START ends one count early. Every later sample therefore lands at
    // HALF-1 + k*CPB clocks after detection, and the registered pulse that
    // follows the stop sample appears exactly HALF + 9*CPB clocks after it.
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(HALF - 2);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CPB - 1);
    localparam logic [2:0]       LAST_BIT   = 3'(DATA_W - 1);

    logic rx_s;
    logic fall;

    uart_rx_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .rx_i   (rx),
        .rx_s_o (rx_s),
        .fall_o (fall)
    );

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [2:0]        bitcnt_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_d;
    logic [DATA_W-1:0] rx_data_q;
    logic              valid_q;
    logic              ferr_q;
`ifdef UART_RX_PARITY_EN
    logic              parity_q;
    logic              perr_q;
`endif

    assign cnt_d   = cnt_q + 1'b1;
    // LSB arrives first, so new bits enter at the top and shift down.
    assign shift_d = {rx_s, shift_q[DATA_W-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bitcnt_q  <= '0;
            shift_q   <= '0;
            rx_data_q <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_q  <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (fall) begin
                        state_q <= ST_START;
                        cnt_q   <= '0;
                    end
                end
                ST_START: begin
                    if (cnt_q == START_LAST) begin
                        cnt_q    <= '0;
                        bitcnt_q <= '0;
                        // Line back high at mid start bit: treat as a glitch.
                        state_q  <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q    <= '0;
                        shift_q  <= shift_d;
                        bitcnt_q <= bitcnt_q + 1'b1;
                        if (bitcnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= ST_PARITY;
`else
                            state_q <= ST_STOP;
`endif
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q    <= '0;
                        parity_q <= rx_s;
                        state_q  <= ST_STOP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
`endif
                ST_STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            // Returning to IDLE here lets a back-to-back start
                            // bit be caught right after this stop sample.
                            state_q <= ST_IDLE;
`ifdef UART_RX_PARITY_EN
                            if (^{shift_q, parity_q}) begin
                                perr_q <= 1'b1;
                            end else begin
                                rx_data_q <= shift_q;
                                valid_q   <= 1'b1;
                            end
`else
                            rx_data_q <= shift_q;
                            valid_q   <= 1'b1;
`endif
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= ST_BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_BREAK: begin
                    // Wait out a held-low line; no start detection here.
                    if (rx_s) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rx_data      = rx_data_q;
    assign rx_valid     = valid_q;
    assign rx_frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign rx_parity_err = perr_q;
`endif
    assign rx_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Scoreboard bench for uart_rx at default parameters (104 clocks per bit).
// Stimulus tasks push the expected pulse kind, rx_data value and arrival cycle;
// a negedge monitor pops and compares whenever the DUT emits a pulse.
// Arrival cycle = cycle rx is driven low + 2 (synchronizer) + 52 + 9*104
// (+104 with UART_RX_PARITY_EN).
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CPB  = 104;
    localparam int HALF = 52;
`ifdef UART_RX_PARITY_EN
    localparam int LAT  = 2 + HALF + 10 * CPB;
`else
    localparam int LAT  = 2 + HALF + 9 * CPB;
`endif

    localparam int K_VALID = 0;
    localparam int K_FERR  = 1;
    localparam int K_PERR  = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         t;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;
    logic       perr_w;

    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t sbq[$];

    uart_rx dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
`ifdef UART_RX_PARITY_EN
        .rx_parity_err(perr_w),
`endif
        .rx_busy      (rx_busy)
    );

`ifndef UART_RX_PARITY_EN
    assign perr_w = 1'b0;
`endif

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual=%0d (0x%0h) required=%0d (0x%0h) at cycle %0d",
                     name, act, act, req, req, cyc);
        end
    endtask

    task automatic drive(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_pulse(input int kind, input logic [7:0] data);
        exp_t e;
        e.kind = kind;
        e.data = data;
        e.t    = cyc + LAT;
        sbq.push_back(e);
    endtask

    // Full frame starting at a negedge; parity bit (when enabled) is correct.
    task automatic send_frame(input logic [7:0] d, input logic stop_b,
                              input int kind, input logic [7:0] exp_data);
        expect_pulse(kind, exp_data);
        drive(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive(d[i], CPB);
`ifdef UART_RX_PARITY_EN
        drive(^d, CPB);
`endif
        drive(stop_b, CPB);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_bad_parity(input logic [7:0] d, input logic [7:0] exp_data);
        expect_pulse(K_PERR, exp_data);
        drive(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive(d[i], CPB);
        drive(~(^d), CPB);
        drive(1'b1, CPB);
    endtask
`endif

    // Monitor: pops one expectation per DUT pulse.
    always @(negedge clk) begin
        exp_t e;
        int   k;
        if (rx_valid || rx_frame_err || perr_w) begin
            k = rx_frame_err ? K_FERR : (perr_w ? K_PERR : K_VALID);
            check("valid_ferr_exclusive", int'(rx_valid & rx_frame_err), 0);
            if (sbq.size() == 0) begin
                check("unexpected_pulse_kind", k, -1);
            end else begin
                e = sbq.pop_front();
                check("pulse_kind", k, e.kind);
                check("pulse_rx_data", int'(rx_data), int'(e.data));
                check("pulse_cycle", cyc, e.t);
            end
        end
    end

    initial begin
        #(40000 * 10);
        $display("FAIL watchdog: actual=timeout required=finish at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        int c0;
        int fallc;
        int seen;

        // Reset state
        rst = 1'b1;
        rx  = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_rx_data", int'(rx_data), 0);
        check("rst_rx_valid", int'(rx_valid), 0);
        check("rst_rx_frame_err", int'(rx_frame_err), 0);
        check("rst_rx_busy", int'(rx_busy), 0);
        rst = 1'b0;

        // Idle line for 2000 clocks: everything stays quiet
        bad = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (rx_data != 8'h00 || rx_valid || rx_frame_err || rx_busy) bad++;
        end
        check("idle_quiet_cycles_bad", bad, 0);

        // Single byte, then a back-to-back pair (arrivals 1040 apart)
        send_frame(8'h55, 1'b1, K_VALID, 8'h55);
        send_frame(8'hA3, 1'b1, K_VALID, 8'hA3);
        send_frame(8'h3C, 1'b1, K_VALID, 8'h3C);
        drive(1'b1, 20);
        check("data_after_pair", int'(rx_data), 8'h3C);

        // 20-clock glitch: no pulse, busy drops within 52 clocks of detection
        c0    = cyc;
        fallc = -1;
        seen  = 0;
        for (int i = 0; i < 200; i++) begin
            rx = (i < 20) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (rx_busy) seen = 1;
            else if (seen == 1 && fallc < 0) fallc = cyc;
        end
        check("glitch_busy_seen", seen, 1);
        check("glitch_busy_fall_in_window",
              int'(fallc >= 0 && (fallc - (c0 + 2)) <= HALF), 1);

        // Framing error from reset state, held-low break, then recovery
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        send_frame(8'h81, 1'b0, K_FERR, 8'h00);
        drive(1'b0, 300);
        check("break_busy", int'(rx_busy), 1);
        drive(1'b1, 20);
        check("data_after_ferr", int'(rx_data), 8'h00);
        send_frame(8'h42, 1'b1, K_VALID, 8'h42);
        drive(1'b1, 20);

        // Reset during data bit 4 of 8'hFF, then 8'h0F
        drive(1'b0, CPB);
        drive(1'b1, 4 * CPB + CPB / 2);
        check("midframe_busy_before_rst", int'(rx_busy), 1);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("midframe_busy_in_rst", int'(rx_busy), 0);
        check("midframe_data_in_rst", int'(rx_data), 0);
        rst = 1'b0;
        drive(1'b1, CPB / 2 + 5 * CPB);
        send_frame(8'h0F, 1'b1, K_VALID, 8'h0F);

`ifdef UART_RX_PARITY_EN
        // Wrong parity: parity error pulse, rx_data keeps previous byte
        send_bad_parity(8'h07, 8'h0F);
`endif

        drive(1'b1, 60);
        check("scoreboard_drained", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
